// File: rtl/bin2bcd_if.sv
// bin2bcd_if: handshake and result bus between a binary source, bin2bcd_seq and the display scanner
//   in_valid/in_ready/bin_in : input handshake (master drives in_valid, bin_in)
//   busy                     : conversion in progress
//   out_valid                : one-cycle pulse when a new result is latched
//   bcd_out/overflow/blank_mask : held result, digit 0 in bcd_out[3:0]
interface bin2bcd_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic [DIGITS-1:0]     blank_mask;

    modport master (
        output in_valid, bin_in,
        input  in_ready, busy, out_valid, bcd_out, overflow, blank_mask
    );

    modport slave (
        input  in_valid, bin_in,
        output in_ready, busy, out_valid, bcd_out, overflow, blank_mask
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to packed BCD converter, one bit per clock
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : bin2bcd_if.slave (input handshake, busy, held BCD result, overflow, leading-zero mask)
//   Macro BIN2BCD_LZB_EN enables leading-zero blank_mask generation; otherwise blank_mask is 0.
module bin2bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input logic     clk,
    input logic     reset_n,
    bin2bcd_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [BIN_W-1:0]  sreg;
    logic [W-1:0]      work;
    logic [W-1:0]      adj;
    logic [CW-1:0]     cnt;
    logic              ovf_acc;
    logic [W-1:0]      bcd_r;
    logic              ovf_r;
    logic              valid_r;
    logic [DIGITS-1:0] mask_r;
    logic [DIGITS-1:0] lzb;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign adj[4*i+:4] = (work[4*i+:4] >= 4'd5) ? work[4*i+:4] + 4'd3 : work[4*i+:4];
    end

`ifdef BIN2BCD_LZB_EN
    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    logic all_zero;
    always_comb begin
        lzb      = '0;
        all_zero = !ovf_acc;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (work[4*i+:4] == 4'd0);
            lzb[i]   = all_zero;
        end
    end
`else
    assign lzb = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sreg    <= '0;
            work    <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            mask_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.in_valid) begin
                    sreg    <= bus.bin_in;
                    work    <= '0;
                    ovf_acc <= 1'b0;
                    cnt     <= CW'(BIN_W);
                    state   <= SHIFT;
                end
            end else if (state == SHIFT) begin
                // The adjusted top bit is the carry out of the last digit; it is dropped and remembered.
                if (adj[W-1])
                    ovf_acc <= 1'b1;
                {work, sreg} <= {adj[W-2:0], sreg, 1'b0};
                cnt          <= cnt - 1'b1;
                if (cnt == CW'(1))
                    state <= DONE;
            end else begin
                bcd_r   <= work;
                ovf_r   <= ovf_acc;
                mask_r  <= lzb;
                valid_r <= 1'b1;
                state   <= IDLE;
            end
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = valid_r;
    assign bus.bcd_out    = bcd_r;
    assign bus.overflow   = ovf_r;
    assign bus.blank_mask = mask_r;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] prev_bcd = '0;

    always #10 clk = ~clk;

    bin2bcd_if #(.BIN_W(32), .DIGITS(8)) bus ();

    bin2bcd_seq #(.BIN_W(32), .DIGITS(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] bin;
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  mask;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] em(input logic [7:0] m);
`ifdef BIN2BCD_LZB_EN
        return m;
`else
        return 8'h00 & m;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_result(input logic [31:0] mid, input logic [31:0] e_bcd, input logic e_ovf,
                               input logic [7:0] e_mask, input logic drop_valid);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            if (n == 5)
                bus.bin_in = mid;
            if (n == 10) begin
                check("hold_bcd", bus.bcd_out, prev_bcd);
                check("busy", bus.busy, 1'b1);
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 33);
        check("bcd_out", bus.bcd_out, e_bcd);
        check("overflow", bus.overflow, e_ovf);
        check("blank_mask", bus.blank_mask, em(e_mask));
        prev_bcd = e_bcd;
        if (drop_valid)
            bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("out_valid_pulse", bus.out_valid, 1'b0);
    endtask

    task automatic convert(input logic [31:0] v, input logic [31:0] e_bcd, input logic e_ovf,
                           input logic [7:0] e_mask);
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("in_ready_drop", bus.in_ready, 1'b0);
        wait_result(v, e_bcd, e_ovf, e_mask, 1'b1);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{32'd12345678,  32'h12345678, 1'b0, 8'h00};
        vecs[1] = '{32'd99999999,  32'h99999999, 1'b0, 8'h00};
        vecs[2] = '{32'd100000000, 32'h00000000, 1'b1, 8'h00};
        vecs[3] = '{32'hFFFFFFFF,  32'h94967295, 1'b1, 8'h00};
        vecs[4] = '{32'd42,        32'h00000042, 1'b0, 8'hFC};
        vecs[5] = '{32'd9,         32'h00000009, 1'b0, 8'hFE};
        vecs[6] = '{32'd10000000,  32'h10000000, 1'b0, 8'h00};
        vecs[7] = '{32'd1234,      32'h00001234, 1'b0, 8'hF0};
        bus.in_valid = 1'b0;
        bus.bin_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_bcd", bus.bcd_out, 32'h0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_mask", bus.blank_mask, 8'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].mask);
        // in_valid held high: second value is accepted on the first idle cycle
        bus.bin_in   = 32'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("held_accept0", bus.in_ready, 1'b0);
        wait_result(32'd1234, 32'h0, 1'b0, 8'hFE, 1'b0);
        check("held_accept1", bus.in_ready, 1'b0);
        wait_result(32'd1234, 32'h00001234, 1'b0, 8'hF0, 1'b1);
        // reset in the middle of a conversion
        bus.bin_in   = 32'd5555;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_bcd", bus.bcd_out, 32'h0);
        check("mid_rst_ovf", bus.overflow, 1'b0);
        check("mid_rst_mask", bus.blank_mask, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        prev_bcd = 32'h0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid)
                pulses++;
        end
        check("no_pulse_after_rst", pulses, 0);
        convert(32'd42, 32'h00000042, 1'b0, 8'hFC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
